// File: rtl/updn_mod_counter.sv
// Up/down counter over 0..max with parallel load, terminal-count strobe and a sticky ovf flag (macro UPDN_CNT_SAT_EN: saturate instead of wrap).
// Latency: q/ovf register on the edge after en/load is sampled; tc is combinational from registered q and current inputs.
// Backpressure: none; en qualifies each edge, load overrides en, rst overrides everything asynchronously.
module updn_mod_counter #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    logic             up_bnd;
    logic             dn_bnd;
    logic [WIDTH-1:0] q_nxt;
    logic             ovf_nxt;

    // q can sit above max after max is lowered; counting up from there is a boundary
    assign up_bnd = ~mode & (q >= max);
    assign dn_bnd = mode & (q == '0);
    assign tc     = ~rst & en & ~load & (up_bnd | dn_bnd);

    always_comb begin
        q_nxt   = q;
        ovf_nxt = ovf;
        if (load) begin
            q_nxt   = (in > max) ? max : in;
            ovf_nxt = 1'b0;
        end else if (en) begin
            if (up_bnd | dn_bnd) begin
                ovf_nxt = 1'b1;
`ifdef UPDN_CNT_SAT_EN
                q_nxt   = mode ? '0 : max;
`else
                q_nxt   = mode ? max : '0;
`endif
            end else if (mode) begin
                q_nxt = (q > max) ? max : (q - WIDTH'(1));
            end else begin
                // q < max here, so the increment cannot leave the 0..max range
                q_nxt = q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= RST_VAL;
            ovf <= 1'b0;
        end else begin
            q   <= q_nxt;
            ovf <= ovf_nxt;
        end
    end

endmodule

// File: doc/updn_mod_counter.md
UPDN_MOD_COUNTER -- requirements
Module: updn_mod_counter

Interface
REQ-001 Parameter: WIDTH, 4, counter/data width in bits (legal 2..32).
REQ-002 Parameter: RST_VAL, 0, value loaded into q on reset (SHALL be <= 2^WIDTH-1).
REQ-003 Port: clk  input  1  single clock, all state rising-edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: en  input  1  count enable.
REQ-006 Port: load  input  1  synchronous parallel load.
REQ-007 Port: mode  input  1  direction; 0 = up, 1 = down.
REQ-008 Port: in  input  WIDTH  load value.
REQ-009 Port: max  input  WIDTH  programmable terminal value; count range 0..max.
REQ-010 Port: q  output  WIDTH  registered count.
REQ-011 Port: tc  output  1  terminal-count strobe, combinational from registered q and inputs.
REQ-012 Port: ovf  output  1  registered sticky boundary-crossing flag.

Function
REQ-013 Priority per clk edge: rst > load > en; en=0 and load=0 -> q, ovf hold.
REQ-014 load=1: q <= (in > max) ? max : in, visible the cycle after the edge; ovf <= 0; mode and en ignored that cycle.
REQ-015 Up (en=1, load=0, mode=0): q < max -> q+1; q >= max -> boundary event.
REQ-016 Down (en=1, load=0, mode=1): q > 0 -> q-1, except q > max -> max; q == 0 -> boundary event.
REQ-017 Boundary event, wrap build: up -> q <= 0; down -> q <= max; ovf <= 1.
REQ-018 tc = en & ~load & ((~mode & q >= max) | (mode & q == 0)); tc is high in exactly the cycle whose edge performs the boundary event.
REQ-019 max = 0: q remains 0, tc = en & ~load every cycle, ovf sets on first enabled cycle.
REQ-020 max may change at any cycle; the new value takes effect on the next edge; q is never left above max by a count step.
REQ-021 Arithmetic is WIDTH bits unsigned; q never reaches 2^WIDTH by increment or underflows below 0 (max = 2^WIDTH-1 wraps cleanly to 0).
REQ-022 mode may toggle between any two cycles; direction applies at the next enabled edge with no extra latency.
REQ-023 ovf only clears on load or rst; simultaneous load and boundary condition -> load wins, ovf = 0, tc = 0.

Reset
REQ-024 rst asserted: q = RST_VAL, ovf = 0 immediately, independent of clk.
REQ-025 rst deasserted: first count occurs at the first rising edge with en=1 or load=1; rst mid-count aborts with no partial update.
REQ-026 tc SHALL be 0 during rst.

Configuration
REQ-027 Macro UPDN_CNT_SAT_EN defined: boundary event saturates -- up holds q = max, down holds q = 0; tc and ovf behave as in REQ-018/017.
REQ-028 Macro UPDN_CNT_SAT_EN undefined: wrap behaviour of REQ-017; no saturation logic present.

Verification (WIDTH=4, RST_VAL=0, wrap build unless noted)
REQ-029 rst=1 at 3 ns between edges -> q=0, ovf=0 before next clk edge; release, en=1, mode=0, max=9, 12 cycles -> q 1..9,0,1,2; tc high only while q=9; ovf=1 after wrap.
REQ-030 q=0, mode=1, max=9, en=1 -> q=9,8,7; tc high in cycle q=0; ovf=1.
REQ-031 load=1, in=14, max=9 -> q=9 next cycle, ovf=0; load=1, in=5, en=1 same cycle -> q=5, no count.
REQ-032 q=7 counting up, max changed to 4 -> next q=0 with tc and ovf; then max=0 -> q stays 0, tc=1 each enabled cycle.
REQ-033 UPDN_CNT_SAT_EN defined, max=15, mode=0, en=1 from q=13 -> q=14,15,15,15; tc=1 at q=15; mode=1 from q=1 -> q=0,0.
REQ-034 en=0 for 5 cycles mid-count, mode toggled -> q, ovf unchanged, tc=0.
